fb_rect_writer: RTL

- Upstream feeder of the VGA frame-buffer write port. Accepts rectangle-fill and screen-clear commands from game logic over a valid/ready handshake.
- Streams one pixel write per clock, in row-major order, onto the w_addr/w_data/we interface of the display block.
- Clips every rectangle to the visible 640x480 area. Frame-buffer address is y*H_RES + x; it is computed incrementally, with no multiplier in the pixel loop.

---
 rtl/fb_rect_writer_pkg.sv | 25 ++
 rtl/fb_rect_writer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fb_rect_writer_pkg.sv
// Shared game constants: visible resolution, VGA timing, command opcodes and the clip helper.
package fb_rect_writer_pkg;

  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int H_FRONT = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BACK  = 48;
  localparam int V_FRONT = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BACK  = 33;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_CLEAR = 2'd1;
  localparam logic [1:0] OP_RECT  = 2'd2;

  // Exclusive end coordinate of a span, clamped to the screen edge; 11-bit sum cannot wrap.
  function automatic logic [10:0] clip_end(input logic [9:0] start, input logic [9:0] len,
                                           input logic [10:0] lim);
    logic [10:0] sum;
    sum = {1'b0, start} + {1'b0, len};
    return (sum > lim) ? lim : sum;
  endfunction

endpackage

// File: rtl/fb_rect_writer.sv
// Clipped rectangle / clear filler streaming one frame-buffer write per clock, row-major.
// First write two cycles after accept, done the cycle after the last write; cmd_ready low while busy (no queueing).
module fb_rect_writer #(
  parameter int H_RES  = fb_rect_writer_pkg::H_RES,
  parameter int V_RES  = fb_rect_writer_pkg::V_RES,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [9:0]        cmd_x,
  input  logic [9:0]        cmd_y,
  input  logic [9:0]        cmd_w,
  input  logic [9:0]        cmd_h,
  input  logic [11:0]       cmd_color,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic              we
);
  import fb_rect_writer_pkg::*;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_FINISH} state_t;

  state_t            state;
  logic [1:0]        op_q;
  logic [9:0]        x_q, y_q, w_q, h_q;
  logic [11:0]       color_q;
  logic [9:0]        x0_q, x_last_q, y_last_q;
  logic [9:0]        cx, cy;
  logic [ADDR_W-1:0] row_base;

  logic [9:0]        x0_c, y0_c;
  logic [10:0]       x1_c, y1_c;
  logic              empty_c;
  logic [ADDR_W-1:0] base0_c;

  always_comb begin
    x0_c    = '0;
    y0_c    = '0;
    x1_c    = 11'(H_RES);
    y1_c    = 11'(V_RES);
    empty_c = 1'b0;
    case (op_q)
      OP_CLEAR: empty_c = 1'b0;
      OP_RECT: begin
        x0_c    = x_q;
        y0_c    = y_q;
        x1_c    = clip_end(x_q, w_q, 11'(H_RES));
        y1_c    = clip_end(y_q, h_q, 11'(V_RES));
        empty_c = ({1'b0, x_q} >= 11'(H_RES)) || ({1'b0, y_q} >= 11'(V_RES)) ||
                  (w_q == 10'd0) || (h_q == 10'd0);
      end
      default: empty_c = 1'b1;
    endcase
    // y*640 as two shifts; only used once per command
    base0_c = (ADDR_W'(y0_c) << 9) + (ADDR_W'(y0_c) << 7);
  end

  logic              row_end, last_px;
  logic [9:0]        nx_cx, nx_cy;
  logic [ADDR_W-1:0] nx_base;

  assign row_end = (cx == x_last_q);
  assign last_px = row_end && (cy == y_last_q);

  always_comb begin
    nx_cx   = cx + 10'd1;
    nx_cy   = cy;
    nx_base = row_base;
    if (row_end) begin
      nx_cx   = x0_q;
      nx_cy   = cy + 10'd1;
      nx_base = row_base + ADDR_W'(H_RES);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      we        <= 1'b0;
      w_addr    <= '0;
      w_data    <= '0;
      op_q      <= OP_NOP;
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      color_q   <= '0;
      x0_q      <= '0;
      x_last_q  <= '0;
      y_last_q  <= '0;
      cx        <= '0;
      cy        <= '0;
      row_base  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            op_q      <= cmd_op;
            x_q       <= cmd_x;
            y_q       <= cmd_y;
            w_q       <= cmd_w;
            h_q       <= cmd_h;
            color_q   <= cmd_color;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          x0_q     <= x0_c;
          x_last_q <= 10'(x1_c - 11'd1);
          y_last_q <= 10'(y1_c - 11'd1);
          if (empty_c) begin
            done  <= 1'b1;
            state <= S_FINISH;
          end else begin
            cx       <= x0_c;
            cy       <= y0_c;
            row_base <= base0_c;
            we       <= 1'b1;
            w_addr   <= base0_c + ADDR_W'(x0_c);
            w_data   <= DATA_W'(color_q);
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (last_px) begin
            we    <= 1'b0;
            done  <= 1'b1;
            state <= S_FINISH;
          end else begin
            cx       <= nx_cx;
            cy       <= nx_cy;
            row_base <= nx_base;
            w_addr   <= nx_base + ADDR_W'(nx_cx);
          end
        end
        default: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
